// File: rtl/packet_tx_device.sv
// Memory-mapped packet transmitter. The CPU assembles 64-bit words through 32-bit register writes.
// Packets reach the 64-bit show-ahead output stream only after they have been committed whole.
module packet_tx_device #(
  parameter int FIFO_DEPTH = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_valid,
  input  logic [31:0] mem_addr,
  input  logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        mem_ready,
  output logic        mem_error,
  input  logic        out_pop,
  output logic        out_nempty,
  output logic [63:0] out_data,
  output logic        out_end
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_W = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0] ONE = (AW+1)'(1);

  localparam logic [7:0] REG_DATA_LO     = 8'h00;
  localparam logic [7:0] REG_DATA_HI     = 8'h04;
  localparam logic [7:0] REG_DATA_HI_END = 8'h08;
  localparam logic [7:0] REG_STATUS      = 8'h0C;
  localparam logic [7:0] REG_ABORT       = 8'h10;
  localparam logic [7:0] REG_DROPS       = 8'h14;

  logic [31:0] stage_lo;
  logic [AW:0] wr_ptr;
  logic [AW:0] commit_ptr;
  logic [AW:0] rd_ptr;
  logic        poison;
  logic        overflow;
  logic [15:0] drops;

  logic [64:0] ram [FIFO_DEPTH];
  logic [64:0] ram_q;
  logic        data_ok;

  logic        accept;
  logic        is_write;
  logic        full_strobe;
  logic [7:0]  offset;
  logic [AW:0] used;
  logic [AW:0] free_words;
  logic        full;
  logic        push;
  logic        push_end;
  logic        do_write;
  logic        pop;
  logic [AW:0] raddr;
  logic [31:0] status_word;
  logic        unused_addr;

  // While mem_ready is high the CPU is still holding the request it just got answered.
  assign accept      = mem_valid && !mem_ready;
  assign offset      = mem_addr[7:0];
  assign unused_addr = ^mem_addr[31:8];
  assign is_write    = mem_wstrb != 4'h0;
  assign full_strobe = mem_wstrb == 4'hF;

  assign used       = wr_ptr - rd_ptr;
  assign free_words = DEPTH_W - used;
  assign full       = used == DEPTH_W;

  assign push     = accept && full_strobe &&
                    (offset == REG_DATA_HI || offset == REG_DATA_HI_END);
  assign push_end = offset == REG_DATA_HI_END;
  assign do_write = push && !poison && !full;

  assign pop   = out_pop && data_ok;
  assign raddr = pop ? rd_ptr + ONE : rd_ptr;

  assign out_nempty = data_ok;
  assign out_data   = data_ok ? ram_q[63:0] : 64'h0;
  assign out_end    = data_ok && ram_q[64];

  always_comb begin
    status_word       = '0;
    status_word[AW:0] = free_words;
    status_word[16]   = wr_ptr != commit_ptr;
    status_word[17]   = poison;
    status_word[31]   = overflow;
  end

  // Word RAM with registered read; the read address runs one word ahead on a pop.
  always_ff @(posedge clk) begin
    if (do_write) begin
      ram[wr_ptr[AW-1:0]] <= {push_end, mem_wdata, stage_lo};
    end
    ram_q <= ram[raddr[AW-1:0]];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_ready  <= 1'b0;
      mem_error  <= 1'b0;
      mem_rdata  <= '0;
      stage_lo   <= '0;
      wr_ptr     <= '0;
      commit_ptr <= '0;
      rd_ptr     <= '0;
      poison     <= 1'b0;
      overflow   <= 1'b0;
      drops      <= '0;
      data_ok    <= 1'b0;
    end else begin
      mem_ready <= accept;
      mem_error <= 1'b0;
      mem_rdata <= '0;
      // The fetched word is valid only if it was committed before this edge.
      data_ok   <= raddr != commit_ptr;
      if (pop) begin
        rd_ptr <= rd_ptr + ONE;
      end

      if (accept && !is_write) begin
        case (offset)
          REG_STATUS: mem_rdata <= status_word;
          REG_DROPS:  mem_rdata <= {16'h0, drops};
          default:    mem_error <= 1'b1;
        endcase
      end else if (accept) begin
        case (offset)
          REG_DATA_LO: begin
            if (full_strobe) stage_lo <= mem_wdata;
            else             mem_error <= 1'b1;
          end
          REG_DATA_HI, REG_DATA_HI_END: begin
            if (!full_strobe) begin
              mem_error <= 1'b1;
            end else begin
              if (do_write) begin
                wr_ptr <= wr_ptr + ONE;
              end else if (!poison) begin
                overflow <= 1'b1;
                poison   <= 1'b1;
              end
              // A poisoned packet is rolled back here, so an oversized packet never blocks the FIFO.
              if (push_end) begin
                if (do_write) begin
                  commit_ptr <= wr_ptr + ONE;
                end else begin
                  wr_ptr <= commit_ptr;
                  poison <= 1'b0;
                  if (drops != 16'hFFFF) drops <= drops + 16'd1;
                end
              end
            end
          end
          REG_STATUS: begin
            if (!full_strobe)      mem_error <= 1'b1;
            else if (mem_wdata[31]) overflow <= 1'b0;
          end
          REG_ABORT: begin
            if (!full_strobe) begin
              mem_error <= 1'b1;
            end else begin
              wr_ptr <= commit_ptr;
              poison <= 1'b0;
            end
          end
          REG_DROPS: drops <= '0;
          default:   mem_error <= 1'b1;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_packet_tx_device.sv
// Bench for packet_tx_device: register-access vector table, directed packet sequences,
// and random packet traffic checked against a queue-based model of the packet rules.
module tb_packet_tx_device;
  localparam int DEPTH = 4;
  localparam int AW = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_valid = 1'b0;
  logic [31:0] mem_addr = '0;
  logic [3:0]  mem_wstrb = '0;
  logic [31:0] mem_wdata = '0;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        mem_error;
  logic        out_pop = 1'b0;
  logic        out_nempty;
  logic [63:0] out_data;
  logic        out_end;

  packet_tx_device #(.FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .mem_error(mem_error),
    .out_pop(out_pop), .out_nempty(out_nempty), .out_data(out_data), .out_end(out_end)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  // Reference model: words written/popped as counts, packets as queues.
  logic [31:0] m_lo;
  int          m_wr;
  int          m_popped;
  bit          m_poison;
  bit          m_ovf;
  int          m_drops;
  logic [64:0] pend[$];
  logic [64:0] exp_q[$];
  logic [64:0] got_q[$];
  int          pop_cyc[$];

  typedef struct {
    logic [7:0]  off;
    logic [3:0]  strb;
    logic [31:0] wd;
    logic        exp_err;
    logic [31:0] exp_rd;
  } vec_t;
  vec_t vecs[12];

  function automatic void chk(string name, logic [64:0] act, logic [64:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endfunction

  function automatic void model_reset();
    m_lo = '0; m_wr = 0; m_popped = 0; m_poison = 0; m_ovf = 0; m_drops = 0;
    pend.delete(); exp_q.delete();
  endfunction

  function automatic logic [31:0] model_status();
    logic [31:0] s;
    s = '0;
    s[AW:0] = (AW+1)'(DEPTH - (m_wr - m_popped));
    s[16] = pend.size() != 0;
    s[17] = m_poison;
    s[31] = m_ovf;
    return s;
  endfunction

  function automatic void model_push(logic [31:0] hi, bit last);
    if (!m_poison) begin
      if (m_wr - m_popped == DEPTH) begin
        m_ovf = 1; m_poison = 1;
      end else begin
        pend.push_back({last, hi, m_lo});
        m_wr++;
      end
    end
    if (last) begin
      if (m_poison) begin
        m_wr -= pend.size();
        pend.delete();
        if (m_drops < 65535) m_drops++;
        m_poison = 0;
      end else begin
        foreach (pend[i]) exp_q.push_back(pend[i]);
        pend.delete();
      end
    end
  endfunction

  function automatic void model_access(logic [7:0] off, logic [3:0] strb, logic [31:0] wd,
                                       output logic err, output logic [31:0] rd);
    err = 0; rd = '0;
    if (strb == 4'h0) begin
      case (off)
        8'h0C:   rd = model_status();
        8'h14:   rd = 32'(m_drops);
        default: err = 1;
      endcase
    end else begin
      case (off)
        8'h00: if (strb != 4'hF) err = 1; else m_lo = wd;
        8'h04, 8'h08: if (strb != 4'hF) err = 1; else model_push(wd, off == 8'h08);
        8'h0C: if (strb != 4'hF) err = 1; else if (wd[31]) m_ovf = 0;
        8'h10: begin
          if (strb != 4'hF) err = 1;
          else begin m_wr -= pend.size(); pend.delete(); m_poison = 0; end
        end
        8'h14:   m_drops = 0;
        default: err = 1;
      endcase
    end
  endfunction

  // One clock with the given pop request; a honoured pop is checked against the model.
  task automatic cycle(input bit do_pop);
    logic [64:0] e;
    out_pop = do_pop;
    if (do_pop && out_nempty) begin
      if (exp_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL pop_uncommitted: got word %0h, required no word", out_data);
      end else begin
        e = exp_q.pop_front();
        chk("pop_data", 65'(out_data), 65'(e[63:0]));
        chk("pop_end", 65'(out_end), 65'(e[64]));
      end
      got_q.push_back({out_end, out_data});
      pop_cyc.push_back(cyc);
      m_popped++;
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic bus(input logic [7:0] off, input logic [3:0] strb, input logic [31:0] wd,
                     input bit p, output logic [31:0] rd, output logic err);
    logic        e_err;
    logic [31:0] e_rd;
    mem_valid = 1'b1; mem_addr = {24'h0, off}; mem_wstrb = strb; mem_wdata = wd;
    model_access(off, strb, wd, e_err, e_rd);
    cycle(p);
    mem_valid = 1'b0;
    chk("ready_pulse", 65'(mem_ready), 65'(1));
    chk("rsp_error", 65'(mem_error), 65'(e_err));
    chk("rsp_rdata", 65'(mem_rdata), 65'(e_rd));
    rd = mem_rdata; err = mem_error;
    cycle(p);
    chk("ready_single", 65'(mem_ready), 65'(0));
  endtask

  task automatic wr(input logic [7:0] off, input logic [31:0] d, input bit p);
    logic [31:0] r;
    logic        e;
    bus(off, 4'hF, d, p, r, e);
  endtask

  task automatic rdreg(input logic [7:0] off, input bit p, output logic [31:0] rd);
    logic e;
    bus(off, 4'h0, 32'h0, p, rd, e);
  endtask

  initial begin
    logic [31:0] rd;
    logic        err;
    int          w;
    int          hi;
    int          len;
    bit          p;

    vecs[0]  = '{8'h0C, 4'h0, 32'h0,        1'b0, 32'h4};
    vecs[1]  = '{8'h14, 4'h0, 32'h0,        1'b0, 32'h0};
    vecs[2]  = '{8'h00, 4'h0, 32'h0,        1'b1, 32'h0};
    vecs[3]  = '{8'h20, 4'h0, 32'h0,        1'b1, 32'h0};
    vecs[4]  = '{8'h04, 4'h3, 32'h12345678, 1'b1, 32'h0};
    vecs[5]  = '{8'h0C, 4'h0, 32'h0,        1'b0, 32'h4};
    vecs[6]  = '{8'h10, 4'h0, 32'h0,        1'b1, 32'h0};
    vecs[7]  = '{8'h18, 4'hF, 32'h1,        1'b1, 32'h0};
    vecs[8]  = '{8'h0C, 4'h1, 32'h80000000, 1'b1, 32'h0};
    vecs[9]  = '{8'h00, 4'hF, 32'h11111111, 1'b0, 32'h0};
    vecs[10] = '{8'h08, 4'h0, 32'h0,        1'b1, 32'h0};
    vecs[11] = '{8'h14, 4'h1, 32'h0,        1'b0, 32'h0};

    model_reset();
    #1;
    chk("rst_nempty", 65'(out_nempty), 65'(0));
    chk("rst_data", 65'(out_data), 65'(0));
    chk("rst_end", 65'(out_end), 65'(0));
    chk("rst_ready", 65'(mem_ready), 65'(0));
    chk("rst_error", 65'(mem_error), 65'(0));
    chk("rst_rdata", 65'(mem_rdata), 65'(0));
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) begin
      bus(vecs[i].off, vecs[i].strb, vecs[i].wd, 1'b0, rd, err);
      chk("vec_error", 65'(err), 65'(vecs[i].exp_err));
      chk("vec_rdata", 65'(rd), 65'(vecs[i].exp_rd));
    end
    chk("vec_no_push", 65'(out_nempty), 65'(0));

    // Basic two-word packet with the consumer always ready.
    got_q.delete(); pop_cyc.delete();
    wr(8'h00, 32'h11111111, 1'b1); wr(8'h04, 32'h22222222, 1'b1);
    wr(8'h00, 32'h33333333, 1'b1); wr(8'h08, 32'h44444444, 1'b1);
    for (int i = 0; i < 6; i++) cycle(1'b1);
    chk("basic_count", 65'(got_q.size()), 65'(2));
    if (got_q.size() == 2) begin
      chk("basic_w0", got_q[0], {1'b0, 64'h2222222211111111});
      chk("basic_w1", got_q[1], {1'b1, 64'h4444444433333333});
      chk("basic_back_to_back", 65'(pop_cyc[1] - pop_cyc[0]), 65'(1));
    end

    // Atomicity: an open packet stays invisible.
    for (int i = 0; i < 3; i++) begin
      wr(8'h00, 32'hA0 + 32'(i), 1'b0); wr(8'h04, 32'hB0 + 32'(i), 1'b0);
    end
    hi = 0;
    for (int i = 0; i < 50; i++) begin
      if (out_nempty) hi++;
      cycle(1'b0);
    end
    chk("atom_hidden", 65'(hi), 65'(0));
    wr(8'h00, 32'hA3, 1'b0); wr(8'h08, 32'hB3, 1'b0);
    w = 0;
    while (!out_nempty && w < 3) begin cycle(1'b0); w++; end
    chk("atom_rise", 65'(out_nempty && w <= 2), 65'(1));
    got_q.delete();
    for (int i = 0; i < 6; i++) cycle(1'b1);
    chk("atom_count", 65'(got_q.size()), 65'(4));

    // Overflow with the consumer stalled.
    for (int i = 0; i < 5; i++) begin
      wr(8'h00, 32'(i), 1'b0); wr(8'h04, 32'hC0 + 32'(i), 1'b0);
    end
    rdreg(8'h0C, 1'b0, rd);
    chk("ovf_poisoned_status", 65'(rd), 65'(32'h80030000));
    wr(8'h08, 32'hCC, 1'b0);
    rdreg(8'h0C, 1'b0, rd);
    chk("ovf_status", 65'(rd), 65'(32'h80000004));
    rdreg(8'h14, 1'b0, rd);
    chk("ovf_drops", 65'(rd), 65'(1));
    chk("ovf_nempty", 65'(out_nempty), 65'(0));
    wr(8'h00, 32'h55, 1'b0); wr(8'h08, 32'h66, 1'b0);
    got_q.delete();
    for (int i = 0; i < 5; i++) cycle(1'b1);
    chk("ovf_next_count", 65'(got_q.size()), 65'(1));
    if (got_q.size() == 1) chk("ovf_next_word", got_q[0], {1'b1, 64'h0000006600000055});
    wr(8'h0C, 32'h80000000, 1'b0);
    rdreg(8'h0C, 1'b0, rd);
    chk("sticky_clear", 65'(rd[31]), 65'(0));
    wr(8'h14, 32'h0, 1'b0);
    rdreg(8'h14, 1'b0, rd);
    chk("drops_clear", 65'(rd), 65'(0));

    // Abort discards the open packet.
    wr(8'h00, 32'h1, 1'b0); wr(8'h04, 32'h2, 1'b0);
    wr(8'h00, 32'h3, 1'b0); wr(8'h04, 32'h4, 1'b0);
    wr(8'h10, 32'h0, 1'b0);
    wr(8'h00, 32'hAA, 1'b0); wr(8'h08, 32'h0, 1'b0);
    got_q.delete();
    for (int i = 0; i < 5; i++) cycle(1'b1);
    chk("abort_count", 65'(got_q.size()), 65'(1));
    if (got_q.size() == 1) chk("abort_word", got_q[0], {1'b1, 64'hAA});
    rdreg(8'h0C, 1'b0, rd);
    chk("abort_free", 65'(rd), 65'(4));

    // Asynchronous reset in the middle of a stream.
    wr(8'h00, 32'h1, 1'b0); wr(8'h08, 32'h2, 1'b0);
    wr(8'h00, 32'h3, 1'b0); wr(8'h08, 32'h4, 1'b0);
    w = 0;
    while (!out_nempty && w < 4) begin cycle(1'b0); w++; end
    cycle(1'b1);
    chk("rst_pre_nempty", 65'(out_nempty), 65'(1));
    out_pop = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk("rst_mid_nempty", 65'(out_nempty), 65'(0));
    chk("rst_mid_data", 65'(out_data), 65'(0));
    chk("rst_mid_end", 65'(out_end), 65'(0));
    #1 rst = 1'b0;
    model_reset();
    @(negedge clk);
    rdreg(8'h0C, 1'b0, rd);
    chk("rst_free", 65'(rd), 65'(4));
    for (int i = 0; i < 3; i++) cycle(1'b0);
    chk("rst_discarded", 65'(out_nempty), 65'(0));

    // Random packet traffic against the model.
    for (int pk = 0; pk < 40; pk++) begin
      len = $urandom_range(1, 5);
      for (int k = 0; k < len; k++) begin
        p = 1'($urandom_range(0, 1));
        wr(8'h00, $urandom, p);
        if (k == len - 1) begin
          if ($urandom_range(0, 7) == 0) wr(8'h10, 32'h0, p);
          else                          wr(8'h08, $urandom, p);
        end else begin
          wr(8'h04, $urandom, p);
        end
      end
      if ($urandom_range(0, 3) == 0) rdreg(8'h0C, 1'($urandom_range(0, 1)), rd);
      w = $urandom_range(0, 3);
      for (int i = 0; i < w; i++) cycle(1'($urandom_range(0, 1)));
    end
    for (int i = 0; i < 30; i++) cycle(1'b1);
    chk("rand_drained", 65'(exp_q.size()), 65'(0));
    chk("rand_nempty", 65'(out_nempty), 65'(0));
    rdreg(8'h0C, 1'b0, rd);
    rdreg(8'h14, 1'b0, rd);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
